seq_detect_prog: RTL

Programmable serial bit-pattern detector, the parametrised successor to the team's fixed 4-bit "1011" Mealy detector. Pattern value, pattern length (1..MAX_LEN) and overlap mode are loaded at run time. The block qualifies input bits with a valid strobe, drives a registered one-cycle match pulse and keeps a saturating match counter. It sits on serial receive paths (frame-sync/preamble search) ahead of the deserialiser.

---
 rtl/seq_detect_prog.sv | 111 +++++++++++
 1 files changed

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector: run-time pattern, length and overlap mode,
// qualified by in_valid, with a registered match pulse and a saturating match counter.
module seq_detect_prog #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               in_valid,
   input  logic               w,
   input  logic               cnt_clr,
   output logic               z,
   output logic [CNT_W-1:0]   match_count,
   output logic               armed,
   output logic               cfg_err
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]         state_q;
   logic [MAX_LEN-1:0] hist_q;
   logic [LEN_W-1:0]   fill_q;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               overlap_q;

   logic [MAX_LEN-1:0] hist_nxt;
   logic [MAX_LEN-1:0] len_mask;
   logic [LEN_W:0]     fill_inc;
   logic               fill_full;
   logic [LEN_W-1:0]   fill_nxt;
   logic               len_ok;
   logic               shift_en;
   logic               match;

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < int'(len_q));
      end
   end

   assign hist_nxt  = {hist_q[MAX_LEN-2:0], w};
   assign fill_inc  = {1'b0, fill_q} + (LEN_W+1)'(1);
   assign fill_full = (fill_inc >= {1'b0, len_q});
   assign fill_nxt  = fill_full ? len_q : fill_inc[LEN_W-1:0];
   assign len_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
   assign shift_en  = (state_q == RUN) && in_valid && !cfg_load;
   // Bits of the history above the programmed length are masked off and never compared.
   assign match     = shift_en && fill_full && (((hist_nxt ^ pat_q) & len_mask) == '0);

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         hist_q    <= '0;
         fill_q    <= '0;
         pat_q     <= '0;
         len_q     <= '0;
         overlap_q <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         cfg_err <= 1'b0;
         if (cfg_load) begin
            hist_q <= '0;
            fill_q <= '0;
            if (len_ok) begin
               state_q   <= RUN;
               pat_q     <= cfg_pattern;
               len_q     <= cfg_len;
               overlap_q <= cfg_overlap;
            end else begin
               state_q <= IDLE;
               cfg_err <= 1'b1;
            end
         end else if (shift_en) begin
            hist_q <= hist_nxt;
            // Without overlap a match empties the history so the next match needs a full fresh pattern.
            if (match && !overlap_q) begin
               fill_q <= '0;
            end else begin
               fill_q <= fill_nxt;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         z           <= 1'b0;
         match_count <= '0;
      end else begin
         z <= match;
         if (cnt_clr) begin
            match_count <= '0;
         end else if (match && (match_count != '1)) begin
            match_count <= match_count + CNT_W'(1);
         end
      end
   end

   assign armed = (state_q == RUN);

endmodule
